// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD display scanner: active-high segment patterns
// ({g,f,e,d,c,b,a}) and digit count.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment decoder; 10..15 show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit 7-segment scanner with frame-synchronous snapshot.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros on digits 3..1.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        scan_tick
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          tick_q, tick;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic [3:0]    cur_nib;
  logic [6:0]    dec_seg;
  logic          blank;
  logic [6:0]    seg_hi;
  logic [3:0]    an_hi;

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    // Reload only at the frame boundary so all four digits come from one sample.
    snap_d  = (tick && idx_q == 2'd3 && !hold) ? digits_in : snap_q;
  end

  assign cur_nib = snap_q[{idx_q, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i is blank when it and every higher digit are zero; digit 0 never is.
  assign blank = (idx_q != 2'd0) && ((snap_q >> {idx_q, 2'b00}) == 16'h0000);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_hi = blank ? SEG_BLANK : dec_seg;
    an_hi  = 4'b0001 << idx_q;
    seg_d  = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    an_d   = SEG_ACTIVE_LOW ? ~an_hi : an_hi;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      tick_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      tick_q  <= tick;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (SCAN_DIV=4, active-low outputs).
module tb_bcd_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic        hold;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        scan_tick;

  int n_cmp = 0;
  int n_bad = 0;
  logic        mon_en = 1'b0;
  logic [10:0] exp_q[$];

  // Hand-inverted active-low patterns for 0..9.
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  bcd_display_scanner #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .hold      (hold),
    .seg       (seg),
    .an        (an),
    .scan_tick (scan_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [15:0] v);
    logic [3:0] nib;
    logic [6:0] s;
    logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      nib = v[4*i +: 4];
      s   = (nib > 4'd9) ? 7'h3F : seg_tbl[nib];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && (v >> (4*i)) == 16'h0) s = 7'h7F;
`endif
      a = ~(4'b0001 << i);
      exp_q.push_back({a, s});
    end
  endtask

  // Monitor: a change of an marks a new digit slot being presented.
  logic [3:0]  prev_an = 4'hF;
  int          run = 0;
  logic [10:0] e;
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (an !== prev_an) begin
        if (prev_an !== 4'hF) chk("slot_len", run, 4);
        if (exp_q.size() == 0) chk("q_underrun", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("an", an, e[10:7]);
          chk("seg", seg, e[6:0]);
        end
        run = 1;
      end else run++;
      chk("scan_tick", scan_tick, (run == 4));
    end
    if (reset) run = 0;
    prev_an = an;
  end

  logic [15:0] plan_d [9] = '{16'h1234, 16'h5678, 16'h5678, 16'h5678, 16'h5678,
                              16'h00A0, 16'h0007, 16'h0000, 16'h9090};
  logic        plan_h [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [15:0] snap_m;

  initial begin
    reset = 1'b1; digits_in = 16'h0; hold = 1'b0;
    #12;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    chk("rst_tick", scan_tick, 0);
    snap_m = 16'h0;
    push_frame(snap_m);
    @(negedge clk); reset = 1'b0; mon_en = 1'b1;
    for (int n = 0; n < 9; n++) begin
      repeat (2) @(posedge clk);
      #1 digits_in = 16'h9999;  // mid-frame decoy, must never be displayed
      repeat (6) @(posedge clk);
      #1 digits_in = plan_d[n]; hold = plan_h[n];
      if (!plan_h[n]) snap_m = plan_d[n];
      push_frame(snap_m);
      repeat (8) @(posedge clk);
    end
    // Asynchronous reset mid-scan, away from any clock edge.
    repeat (6) @(posedge clk);
    #3 mon_en = 1'b0; reset = 1'b1;
    #1;
    chk("arst_seg", seg, 7'h7F);
    chk("arst_an", an, 4'hF);
    chk("arst_tick", scan_tick, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("arst_hold_an", an, 4'hF);
    digits_in = 16'h4321;
    push_frame(16'h0000);
    @(negedge clk); reset = 1'b0; mon_en = 1'b1;
    repeat (16) @(posedge clk);
    #2 mon_en = 1'b0;
    chk("q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
